cmsdk_apb4_eg_master: RTL and testbench

//  Single-outstanding APB4 master driving the example APB4 slave directly on PSEL/PENABLE/PADDR.

---
 rtl/cmsdk_apb4_pkg.sv | 16 +
 rtl/cmsdk_apb4_eg_master.sv | 147 ++++++++++++++
 tb/tb_cmsdk_apb4_eg_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmsdk_apb4_pkg.sv
// Shared definitions for the example APB4 master: FSM encoding and bus constants.
package cmsdk_apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    // Reads never assert byte strobes on the bus.
    localparam logic [3:0] PSTRB_READ    = 4'b0000;

    // PPROT value driven before any command has been accepted.
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/cmsdk_apb4_eg_master.sv
// Single-outstanding APB4 master: turns one valid/ready command into one APB4
// transfer and returns a one-cycle response pulse. An optional PREADY timeout
// aborts transfers to a slave that never responds.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | no transfer; cmd_ready=1, a valid command is latched here
//  ST_SETUP  | APB setup phase: PSEL=1, PENABLE=0, timeout counter cleared
//  ST_ACCESS | APB access phase: PSEL=1, PENABLE=1, wait for PREADY/timeout
module cmsdk_apb4_eg_master
    import cmsdk_apb4_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 16,
    parameter int CNTWIDTH  = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    input  logic [2:0]           cmd_prot,

    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,

    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    // The abort fires on the ACCESS cycle whose count, before incrementing,
    // is TIMEOUT-1: that cycle is the TIMEOUT-th stalled ACCESS cycle.
    localparam logic [CNTWIDTH-1:0] TO_LIMIT =
        CNTWIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    apb_state_t          state;
    apb_state_t          state_nxt;
    logic [CNTWIDTH-1:0] to_cnt;
    logic                to_hit;
    logic                cmd_accept;
    logic                xfer_done;
    logic                xfer_abort;

    assign to_hit    = (TIMEOUT != 0) && (to_cnt == TO_LIMIT);

    assign cmd_ready = (state == ST_IDLE);
    assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE   = (state == ST_ACCESS);

    // State register with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode plus the accept / completion / abort strobes.
    always_comb begin
        state_nxt  = state;
        cmd_accept = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_nxt  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY on the limit cycle is still a normal completion.
                if (PREADY) begin
                    xfer_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (to_hit) begin
                    xfer_abort = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timeout counter: cleared in SETUP so it starts at 0 on entering ACCESS.
    always_ff @(posedge PCLK) begin
        if (!PRESETn)                             to_cnt <= '0;
        else if (state == ST_SETUP)               to_cnt <= '0;
        else if ((state == ST_ACCESS) && !PREADY) to_cnt <= to_cnt + CNTWIDTH'(1);
    end

    // Bus address/control/data latched on accept and held until the next accept.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= PSTRB_READ;
            PPROT  <= PPROT_DEFAULT;
        end else if (cmd_accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            PSTRB  <= cmd_write ? cmd_strb : PSTRB_READ;
            PPROT  <= cmd_prot;
        end
    end

    // Response registers: pulse rsp_valid for one cycle, hold payload otherwise.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= xfer_done | xfer_abort;
            if (xfer_done) begin
                rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (xfer_abort) begin
                rsp_rdata   <= 32'h0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_apb4_eg_master.sv
// Directed bench for the example APB4 master; the slave side is driven
// cycle by cycle from the stimulus, expected values are hand-computed.
module tb_cmsdk_apb4_eg_master;

    localparam int AW = 12;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_total = 0;
    int n_pass  = 0;

    cmsdk_apb4_eg_master #(
        .ADDRWIDTH (AW),
        .TIMEOUT   (4),
        .CNTWIDTH  (8)
    ) u_dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_cmd(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        set_cmd('0, 1'b0, 32'h0, 4'h0, 3'h0);
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel",      32'(PSEL),      32'd0);
        chk("rst_penable",   32'(PENABLE),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr",     32'(PADDR),     32'd0);
        PRESETn = 1'b1;
        step();

        // Zero-wait write
        set_cmd(12'h004, 1'b1, 32'hA5A5_0001, 4'hF, 3'b010);
        cmd_valid = 1'b1;
        PRDATA    = 32'h5555_AAAA;
        chk("wr_ready_idle", 32'(cmd_ready), 32'd1);
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        chk("wr_setup_psel",    32'(PSEL),    32'd1);
        chk("wr_setup_penable", 32'(PENABLE), 32'd0);
        chk("wr_setup_paddr",   32'(PADDR),   32'h004);
        chk("wr_setup_pwrite",  32'(PWRITE),  32'd1);
        chk("wr_setup_pwdata",  PWDATA,       32'hA5A5_0001);
        chk("wr_setup_pstrb",   32'(PSTRB),   32'hF);
        chk("wr_setup_pprot",   32'(PPROT),   32'h2);
        chk("wr_setup_ready",   32'(cmd_ready), 32'd0);
        PREADY = 1'b1;
        step();                                   // T+2 ACCESS
        chk("wr_acc_psel",    32'(PSEL),      32'd1);
        chk("wr_acc_penable", 32'(PENABLE),   32'd1);
        chk("wr_acc_rsp",     32'(rsp_valid), 32'd0);
        step();                                   // T+3 response
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_err",   32'(rsp_err),   32'd0);
        chk("wr_rsp_rdata", rsp_rdata,      32'h0);
        chk("wr_rsp_psel",  32'(PSEL),      32'd0);
        chk("wr_rsp_ready", 32'(cmd_ready), 32'd1);
        PREADY = 1'b0;
        step();
        chk("wr_post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wr_post_paddr",     32'(PADDR),     32'h004);
        chk("wr_post_pwdata",    PWDATA,         32'hA5A5_0001);

        // Zero-wait read; strobes must be suppressed
        set_cmd(12'h008, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b001);
        cmd_valid = 1'b1;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        chk("rd_setup_pstrb",  32'(PSTRB),  32'h0);
        chk("rd_setup_pwrite", 32'(PWRITE), 32'd0);
        chk("rd_setup_paddr",  32'(PADDR),  32'h008);
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        step();                                   // T+2 ACCESS
        chk("rd_acc_rsp", 32'(rsp_valid), 32'd0);
        step();                                   // T+3
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata,      32'h1234_5678);
        chk("rd_rsp_err",   32'(rsp_err),   32'd0);
        PREADY = 1'b0;
        PRDATA = 32'h0;
        step();
        chk("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

        // Read with 3 wait states, error on completion (4th ACCESS cycle = limit)
        set_cmd(12'h00C, 1'b0, 32'h0, 4'h0, 3'b000);
        cmd_valid = 1'b1;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        step();                                   // T+2 ACCESS
        for (int i = 0; i < 3; i++) begin
            chk("ws_paddr",   32'(PADDR),     32'h00C);
            chk("ws_penable", 32'(PENABLE),   32'd1);
            chk("ws_rsp",     32'(rsp_valid), 32'd0);
            step();
        end
        PREADY  = 1'b1;                           // T+5
        PSLVERR = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
        chk("ws_last_paddr", 32'(PADDR), 32'h00C);
        step();                                   // T+6
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk("ws_rsp_valid",   32'(rsp_valid),   32'd1);
        chk("ws_rsp_err",     32'(rsp_err),     32'd1);
        chk("ws_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("ws_rsp_rdata",   rsp_rdata,        32'hDEAD_BEEF);
        step();

        // Timeout: PREADY stuck low
        set_cmd(12'h010, 1'b0, 32'h0, 4'h0, 3'b000);
        PRDATA    = 32'hFFFF_FFFF;
        cmd_valid = 1'b1;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        step();                                   // T+2 ACCESS
        for (int i = 0; i < 4; i++) begin
            chk("to_psel", 32'(PSEL),      32'd1);
            chk("to_rsp",  32'(rsp_valid), 32'd0);
            step();
        end
        chk("to_psel_drop",    32'(PSEL),        32'd0);
        chk("to_rsp_valid",    32'(rsp_valid),   32'd1);
        chk("to_rsp_err",      32'(rsp_err),     32'd1);
        chk("to_rsp_timeout",  32'(rsp_timeout), 32'd1);
        chk("to_rsp_rdata",    rsp_rdata,        32'h0);
        step();

        // Back-to-back: cmd_valid held high across two commands
        set_cmd(12'h020, 1'b1, 32'h0000_0020, 4'h3, 3'b000);
        PREADY    = 1'b1;
        PRDATA    = 32'hCAFE_0024;
        cmd_valid = 1'b1;
        step();                                   // T+1 SETUP (cmd 1)
        set_cmd(12'h024, 1'b0, 32'h0, 4'hF, 3'b100);
        chk("b2b_setup_ready", 32'(cmd_ready), 32'd0);
        chk("b2b_setup_paddr", 32'(PADDR),     32'h020);
        step();                                   // T+2 ACCESS
        chk("b2b_acc_ready", 32'(cmd_ready), 32'd0);
        step();                                   // T+3 response 1, accepts cmd 2
        chk("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp1_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_rsp1_rdata", rsp_rdata,      32'h0);
        step();                                   // T+4 SETUP (cmd 2)
        cmd_valid = 1'b0;
        chk("b2b_s2_psel",    32'(PSEL),      32'd1);
        chk("b2b_s2_penable", 32'(PENABLE),   32'd0);
        chk("b2b_s2_paddr",   32'(PADDR),     32'h024);
        chk("b2b_s2_pwrite",  32'(PWRITE),    32'd0);
        chk("b2b_s2_pstrb",   32'(PSTRB),     32'h0);
        chk("b2b_s2_pprot",   32'(PPROT),     32'h4);
        chk("b2b_s2_rsp",     32'(rsp_valid), 32'd0);
        step();                                   // T+5 ACCESS
        step();                                   // T+6 response 2
        chk("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp2_rdata", rsp_rdata,      32'hCAFE_0024);
        PREADY = 1'b0;
        step();

        // Reset asserted during ACCESS
        set_cmd(12'h030, 1'b0, 32'h0, 4'h0, 3'b000);
        cmd_valid = 1'b1;
        step();                                   // SETUP
        cmd_valid = 1'b0;
        step();                                   // ACCESS
        chk("mr_acc_penable", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        PREADY  = 1'b1;
        step();
        chk("mr_psel",      32'(PSEL),      32'd0);
        chk("mr_penable",   32'(PENABLE),   32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        PRESETn = 1'b1;
        step();
        chk("mr_post_rsp",  32'(rsp_valid), 32'd0);
        chk("mr_post_psel", 32'(PSEL),      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
